// File: rtl/adjacent_swap_scheduler_if.sv
// Swap-checker bus: the scheduler presents a four-city window and restarts the
// checker; the checker answers with a decision, completion and length delta.
interface adjacent_swap_scheduler_if;
  logic        chk_rst;
  logic [7:0]  chk_x1, chk_y1, chk_x2, chk_y2;
  logic [7:0]  chk_x3, chk_y3, chk_x4, chk_y4;
  logic        chk_res;
  logic        chk_complete;
  logic [31:0] chk_diff;

  modport master (
    output chk_rst, chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3, chk_x4, chk_y4,
    input  chk_res, chk_complete, chk_diff
  );

  modport slave (
    input  chk_rst, chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3, chk_x4, chk_y4,
    output chk_res, chk_complete, chk_diff
  );
endinterface

// File: rtl/adjacent_swap_scheduler.sv
// Sweeps a sliding four-city window over the tour, asks an external checker
// whether swapping the middle pair helps, and applies accepted swaps in passes.
module adjacent_swap_scheduler #(
  parameter int N        = 16,
  parameter int MAX_PASS = 8,
  parameter int TIMEOUT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_we,
  input  logic [5:0]  load_addr,
  input  logic [7:0]  load_x,
  input  logic [7:0]  load_y,
  input  logic [5:0]  rd_addr,
  output logic [7:0]  rd_x,
  output logic [7:0]  rd_y,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] total_gain,
  output logic [15:0] swap_count,
  output logic [7:0]  pass_count,
  adjacent_swap_scheduler_if.master chk
);
  localparam int AW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, APPLY, NEXT, FIN} state_t;

  state_t        state;
  logic [AW-1:0] i;
  logic [WW-1:0] wcnt;
  logic          swapped;
  logic [7:0]    tour_x [N];
  logic [7:0]    tour_y [N];
  logic [AW-1:0] i1, i2, i3;

  assign i1 = i + AW'(1);
  assign i2 = i + AW'(2);
  assign i3 = i + AW'(3);

  // Tour storage has no reset; loads are locked out for the whole run.
  always_ff @(posedge clk) begin
    if (!rst && state == APPLY && chk.chk_res) begin
      tour_x[i1] <= tour_x[i2];
      tour_y[i1] <= tour_y[i2];
      tour_x[i2] <= tour_x[i1];
      tour_y[i2] <= tour_y[i1];
    end else if (load_we && !busy && int'(load_addr) < N) begin
      tour_x[load_addr[AW-1:0]] <= load_x;
      tour_y[load_addr[AW-1:0]] <= load_y;
    end
  end

  always_comb begin
    rd_x = '0;
    rd_y = '0;
    if (int'(rd_addr) < N) begin
      rd_x = tour_x[rd_addr[AW-1:0]];
      rd_y = tour_y[rd_addr[AW-1:0]];
    end
  end

  always_comb begin
    chk.chk_x1 = tour_x[i];
    chk.chk_y1 = tour_y[i];
    chk.chk_x2 = tour_x[i1];
    chk.chk_y2 = tour_y[i1];
    chk.chk_x3 = tour_x[i2];
    chk.chk_y3 = tour_y[i2];
    chk.chk_x4 = tour_x[i3];
    chk.chk_y4 = tour_y[i3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      chk.chk_rst <= 1'b0;
      total_gain  <= '0;
      swap_count  <= '0;
      pass_count  <= '0;
      i           <= '0;
      wcnt        <= '0;
      swapped     <= 1'b0;
    end else begin
      done        <= 1'b0;
      chk.chk_rst <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state       <= LAUNCH;
          busy        <= 1'b1;
          chk.chk_rst <= 1'b1;
          i           <= '0;
          pass_count  <= 8'd1;
          total_gain  <= '0;
          swap_count  <= '0;
          err         <= 1'b0;
          swapped     <= 1'b0;
        end
        LAUNCH: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (chk.chk_complete) begin
            state <= APPLY;
          end else if (int'(wcnt) == TIMEOUT) begin
            state <= FIN;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        APPLY: begin
          state <= NEXT;
          if (chk.chk_res) begin
            total_gain <= total_gain + chk.chk_diff;
            if (swap_count != '1) swap_count <= swap_count + 16'd1;
            swapped <= 1'b1;
          end
        end
        NEXT: begin
          if (int'(i) < N - 4) begin
            i           <= i + AW'(1);
            state       <= LAUNCH;
            chk.chk_rst <= 1'b1;
          end else if (swapped && int'(pass_count) < MAX_PASS) begin
            pass_count  <= pass_count + 8'd1;
            i           <= '0;
            swapped     <= 1'b0;
            state       <= LAUNCH;
            chk.chk_rst <= 1'b1;
          end else begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adjacent_swap_scheduler.sv
// Directed bench: an N=4 and an N=6 scheduler, each with a behavioural checker
// whose answers are selected per run by a mode code.
module tb_adjacent_swap_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, start, load_we, busy, done, err, chk_rst_v;
  logic [1:0][5:0]   load_addr, rd_addr;
  logic [1:0][7:0]   load_x, load_y, rd_x, rd_y, pass_count;
  logic [1:0][31:0]  total_gain;
  logic [1:0][15:0]  swap_count;

  // mode 0: never swap, 1: swap (diff 5) on first call only, 2: always swap (diff 1), 3: never complete
  logic [1:0][1:0]   mode;
  logic [1:0][3:0]   ccnt = '0;
  logic [1:0][7:0]   calls = '0;
  logic [1:0][7:0]   done_cnt = '0;

  int checks = 0;
  int failures = 0;

  adjacent_swap_scheduler_if cif0 ();
  adjacent_swap_scheduler_if cif1 ();

  adjacent_swap_scheduler #(.N(4), .MAX_PASS(8), .TIMEOUT(32)) u4 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .load_we(load_we[0]),
    .load_addr(load_addr[0]), .load_x(load_x[0]), .load_y(load_y[0]),
    .rd_addr(rd_addr[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .total_gain(total_gain[0]),
    .swap_count(swap_count[0]), .pass_count(pass_count[0]), .chk(cif0)
  );

  adjacent_swap_scheduler #(.N(6), .MAX_PASS(8), .TIMEOUT(32)) u6 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .load_we(load_we[1]),
    .load_addr(load_addr[1]), .load_x(load_x[1]), .load_y(load_y[1]),
    .rd_addr(rd_addr[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .total_gain(total_gain[1]),
    .swap_count(swap_count[1]), .pass_count(pass_count[1]), .chk(cif1)
  );

  function automatic logic m_res(input logic [1:0] m, input logic [7:0] c);
    return (m == 2'd2) || (m == 2'd1 && c == 8'd1);
  endfunction

  assign chk_rst_v[0]      = cif0.chk_rst;
  assign chk_rst_v[1]      = cif1.chk_rst;
  assign cif0.chk_complete = (mode[0] != 2'd3) && (ccnt[0] == 4'd8);
  assign cif1.chk_complete = (mode[1] != 2'd3) && (ccnt[1] == 4'd8);
  assign cif0.chk_res      = m_res(mode[0], calls[0]);
  assign cif1.chk_res      = m_res(mode[1], calls[1]);
  assign cif0.chk_diff     = (mode[0] == 2'd1) ? 32'd5 : 32'd1;
  assign cif1.chk_diff     = (mode[1] == 2'd1) ? 32'd5 : 32'd1;

  // Checker latency of 8 cycles after each restart; calls counts restarts per run.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (start[d] && !busy[d]) calls[d] <= '0;
      else if (chk_rst_v[d])    calls[d] <= calls[d] + 8'd1;
      if (chk_rst_v[d]) ccnt[d] <= 4'd1;
      else if (ccnt[d] != 4'd0 && ccnt[d] < 4'd8) ccnt[d] <= ccnt[d] + 4'd1;
      if (done[d]) done_cnt[d] <= done_cnt[d] + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int d, input logic [5:0] a, input logic [7:0] x, input logic [7:0] y);
    load_we[d] = 1'b1; load_addr[d] = a; load_x[d] = x; load_y[d] = y;
    @(negedge clk);
    load_we[d] = 1'b0;
  endtask

  task automatic check_rd(input int d, input logic [5:0] a, input logic [7:0] ex,
                          input logic [7:0] ey, input string tag);
    rd_addr[d] = a;
    #1;
    check({tag, "_x"}, 32'(rd_x[d]), 32'(ex));
    check({tag, "_y"}, 32'(rd_y[d]), 32'(ey));
  endtask

  task automatic launch(input int d, input logic [1:0] m, input string tag);
    mode[d] = m; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check({tag, "_busy"}, 32'(busy[d]), 32'd1);
    check({tag, "_chk_rst"}, 32'(chk_rst_v[d]), 32'd1);
  endtask

  task automatic wait_done(input int d, input string tag);
    for (int c = 0; c < 3000 && !done[d]; c++) @(negedge clk);
    if (!done[d]) begin
      checks++; failures++;
      $error("FAIL %s_done_timeout observed=0 expected=1", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_counts(input int d, input logic [31:0] g, input logic [15:0] s,
                              input logic [7:0] p, input logic e, input string tag);
    check({tag, "_gain"}, total_gain[d], g);
    check({tag, "_swaps"}, 32'(swap_count[d]), 32'(s));
    check({tag, "_passes"}, 32'(pass_count[d]), 32'(p));
    check({tag, "_err"}, 32'(err[d]), 32'(e));
    check({tag, "_busy_end"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    logic [7:0] dc;
    int c;
    rst = '1; start = '0; load_we = '0; load_addr = '0; load_x = '0; load_y = '0;
    rd_addr = '0; mode = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_counts(d, 32'd0, 16'd0, 8'd0, 1'b0, "reset");
      check("reset_done", 32'(done[d]), 32'd0);
      check("reset_chk_rst", 32'(chk_rst_v[d]), 32'd0);
    end
    rst = '0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) load(0, 6'(k), 8'(k), 8'(k));
    for (int k = 0; k < 6; k++) load(1, 6'(k), 8'(16 + k), 8'(32 + k));
    load(0, 6'd5, 8'h99, 8'h99);
    check_rd(0, 6'd1, 8'd1, 8'd1, "oob_write_no_alias");
    check_rd(0, 6'd5, 8'd0, 8'd0, "oob_read_zero");

    // first call accepts a swap, the second pass finds nothing
    dc = done_cnt[0];
    launch(0, 2'd1, "p1");
    check("p1_window_x2", 32'(cif0.chk_x2), 32'd1);
    wait_done(0, "p1");
    check_counts(0, 32'd5, 16'd1, 8'd2, 1'b0, "p1");
    check("p1_done_pulses", 32'(done_cnt[0] - dc), 32'd1);
    check("p1_calls", 32'(calls[0]), 32'd2);
    check_rd(0, 6'd1, 8'd2, 8'd2, "p1_pos1");
    check_rd(0, 6'd2, 8'd1, 8'd1, "p1_pos2");

    launch(1, 2'd0, "p2");
    wait_done(1, "p2");
    check_counts(1, 32'd0, 16'd0, 8'd1, 1'b0, "p2");
    check("p2_chk_rst_pulses", 32'(calls[1]), 32'd3);
    check_rd(1, 6'd2, 8'd18, 8'd34, "p2_pos2");

    // a swap every window keeps the run going until MAX_PASS
    launch(0, 2'd2, "p3");
    wait_done(0, "p3");
    check_counts(0, 32'd8, 16'd8, 8'd8, 1'b0, "p3");
    check("p3_calls", 32'(calls[0]), 32'd8);
    check_rd(0, 6'd1, 8'd2, 8'd2, "p3_pos1");

    launch(1, 2'd3, "p4");
    c = 0;
    while (!done[1] && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("p4_timeout_latency", 32'(c), 32'd34);
    check("p4_done", 32'(done[1]), 32'd1);
    repeat (2) @(negedge clk);
    check_counts(1, 32'd0, 16'd0, 8'd1, 1'b1, "p4");
    check_rd(1, 6'd3, 8'd19, 8'd35, "p4_pos3");

    // abort during the second window's wait
    dc = done_cnt[1];
    launch(1, 2'd0, "p5");
    check("p5_err_cleared", 32'(err[1]), 32'd0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!chk_rst_v[1] && c < 100);
    check("p5_second_launch", 32'(chk_rst_v[1]), 32'd1);
    repeat (3) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check_counts(1, 32'd0, 16'd0, 8'd0, 1'b0, "p5_abort");
    repeat (4) @(negedge clk);
    check("p5_no_done", 32'(done_cnt[1] - dc), 32'd0);
    launch(1, 2'd0, "p5b");
    wait_done(1, "p5b");
    check_counts(1, 32'd0, 16'd0, 8'd1, 1'b0, "p5b");
    check("p5b_done_pulses", 32'(done_cnt[1] - dc), 32'd1);
    check("p5b_calls", 32'(calls[1]), 32'd3);

    launch(0, 2'd0, "p6");
    load(0, 6'd3, 8'h77, 8'h88);
    wait_done(0, "p6");
    check_rd(0, 6'd3, 8'd3, 8'd3, "p6_busy_write");
    load(0, 6'd3, 8'h77, 8'h88);
    check_rd(0, 6'd3, 8'h77, 8'h88, "p6_idle_write");

    // write and start in the same idle cycle
    mode[0] = 2'd0;
    load_we[0] = 1'b1; load_addr[0] = 6'd0; load_x[0] = 8'h40; load_y[0] = 8'h41;
    start[0] = 1'b1;
    @(negedge clk);
    load_we[0] = 1'b0; start[0] = 1'b0;
    check("p7_window_x1", 32'(cif0.chk_x1), 32'h40);
    check("p7_window_y1", 32'(cif0.chk_y1), 32'h41);
    check("p7_window_x4", 32'(cif0.chk_x4), 32'h77);
    wait_done(0, "p7");
    check_rd(0, 6'd0, 8'h40, 8'h41, "p7_pos0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
